avalon_mm_read_arbiter: RTL and testbench
=========================================

// Module: avalon_mm_read_arbiter
// PURPOSE
//  Shares one 16-bit pipelined Avalon-MM read master (SDRAM/flash side, 25-bit halfword address)
//  between N_REQ 32-bit Avalon-MM read requesters (pixel fetch, audio fetch, CPU).
//  Each granted 32-bit read becomes two 16-bit beats (low half first). Beats are reassembled
//  little-endian and returned to the owner. Round-robin arbitration; rq_lock honoured up to LOCK_LIMIT.
// PARAMETERS
//  N_REQ       2   number of requesters (2..4)
//  LOCK_LIMIT  8   max consecutive locked transactions by one owner before forced re-arbitration
// PORTS
//  clock               in   1          single clock; all logic posedge
//  reset               in   1          synchronous, active-high
//  rq_address[N_REQ]   in   32         byte address per requester; bits[1:0] ignored (word aligned)
//  rq_read[N_REQ]      in   1          read request, held until waitrequest low
//  rq_lock[N_REQ]      in   1          keep grant for this requester's next read
//  rq_waitrequest[N_REQ] out 1         high while rq_read pending and data not yet returned
//  rq_readdata[N_REQ]  out  32         assembled word; valid only with rq_readdatavalid
//  rq_readdatavalid[N_REQ] out 1       one-cycle strobe, same cycle as waitrequest low
//  m_address           out  25         halfword address
//  m_read              out  1          doubles as chipselect
//  m_byteenable_n      out  2          constant 2'b00 (both bytes, active-low)
//  m_waitrequest       in   1          beat not accepted while high
//  m_readdata          in   16         return beat
//  m_readdatavalid     in   1          return beat strobe, in issue order
// BEHAVIOUR
//  Reset: state IDLE, grant=none, rr pointer=0, lock count=0, m_read=0, m_address=0,
//   rq_readdatavalid=0, rq_readdata=0, assembly regs=0, beat counters=0.
//  rq_waitrequest[i] = rq_read[i] & ~(state==RESP & owner==i): combinational, all other cycles high.
//  FSM: IDLE -> ISSUE_LO -> ISSUE_HI -> WAIT_DATA -> RESP -> IDLE.
//   IDLE: if any rq_read, pick owner (lock rule first, else round-robin starting at rr pointer),
//    latch word addr A=rq_address[25:2]; next ISSUE_LO.
//   ISSUE_LO: m_read=1, m_address={A,1'b0}; advance when m_waitrequest low.
//   ISSUE_HI: m_read=1, m_address={A,1'b1}; advance when m_waitrequest low.
//   WAIT_DATA: m_read=0; stay until 2 beats received.
//   RESP: readdata/readdatavalid to owner for exactly 1 cycle; rr pointer=owner+1 mod N_REQ.
//  Beat capture in ISSUE_HI and WAIT_DATA: beat 0 -> [15:0], beat 1 -> [31:16].
//   A beat arriving in ISSUE_HI (the low beat returning early) must be captured.
//  Latency, zero wait states, 1-cycle memory read latency: rq_read at cycle 0 -> RESP at cycle 5.
//  Lock: in RESP, if rq_lock[owner]=1 and lock count<LOCK_LIMIT, count++ and owner keeps priority
//   at next IDLE if it requests that cycle. Otherwise count=0 and normal round-robin.
//   A non-owner never waits more than LOCK_LIMIT+1 transactions.
//  Simultaneous requests: round-robin order from rr pointer; lowest index wins on first arbitration.
//  Owner drops rq_read mid-transaction (protocol error): finish bus beats, suppress readdatavalid.
//  m_readdatavalid in IDLE/RESP, or a third beat: ignored, no state change.
//  Reset mid-operation: abort to IDLE same edge; no strobes out; outstanding memory beats ignored.
//  Address bits [31:26] are discarded (no wrap detection).
// STRUCTURE
//  Package avalon_arb_pkg: typedef enum {IDLE,ISSUE_LO,ISSUE_HI,WAIT_DATA,RESP} arb_state_t;
//   localparams M_ADDR_W=25, M_DATA_W=16, S_DATA_W=32.
//  Sub-module rr_arbiter #(N): req vector, pointer, lock_owner/lock_valid in -> one-hot grant + index.
//  Remainder (FSM, beat counters, assembly, lock counter) in this module.
// TESTING
//  1 req0 reads 0x0000_0010, memory returns 0x1234 then 0xABCD -> m_address 0x8 then 0x9;
//    rq_readdata[0]=0xABCD1234 with one-cycle valid at cycle 5.
//  2 req0 and req1 raise read in the same cycle -> req0 served first, then req1; rr pointer ends at 0.
//  3 req1 holds lock with continuous reads while req0 waits, LOCK_LIMIT=8 -> 8 locked reads by req1,
//    then req0 granted.
//  4 m_waitrequest high 3 cycles on the low beat, low beat returned during ISSUE_HI -> m_address held
//    stable; data assembled correctly.
//  5 reset pulsed during WAIT_DATA, stale beat arrives next cycle -> no rq_readdatavalid; next read
//    returns correct fresh data.
//  6 owner drops rq_read after ISSUE_LO -> both beats still issued; no readdatavalid; FSM back in IDLE.

Source files
------------

// File: rtl/avalon_arb_pkg.sv
// rtl/avalon_arb_pkg.sv - shared types and widths for the Avalon-MM read arbiter
package avalon_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_LO,
        ISSUE_HI,
        WAIT_DATA,
        RESP
    } arb_state_t;

    localparam int M_ADDR_W = 25;
    localparam int M_DATA_W = 16;
    localparam int S_DATA_W = 32;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick with a sticky lock owner taking precedence
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    input  logic [IDX_W-1:0] lock_owner_i,
    input  logic             lock_valid_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    always_comb begin
        int cand;
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        if (lock_valid_i && req_i[lock_owner_i]) begin
            grant_o[lock_owner_i] = 1'b1;
            idx_o                 = lock_owner_i;
            valid_o               = 1'b1;
        end else begin
            // Scan starting at the pointer so the last owner goes to the back.
            for (int k = 0; k < N; k++) begin
                cand = (int'(ptr_i) + k) % N;
                if (!valid_o && req_i[cand]) begin
                    grant_o[cand] = 1'b1;
                    idx_o         = IDX_W'(cand);
                    valid_o       = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/avalon_mm_read_arbiter.sv
// rtl/avalon_mm_read_arbiter.sv - N 32-bit read requesters sharing one 16-bit pipelined read master
module avalon_mm_read_arbiter
    import avalon_arb_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int LOCK_LIMIT = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [31:0]         rq_address [N_REQ],
    input  logic [N_REQ-1:0]    rq_read,
    input  logic [N_REQ-1:0]    rq_lock,
    output logic [N_REQ-1:0]    rq_waitrequest,
    output logic [S_DATA_W-1:0] rq_readdata [N_REQ],
    output logic [N_REQ-1:0]    rq_readdatavalid,
    output logic [M_ADDR_W-1:0] m_address,
    output logic                m_read,
    output logic [1:0]          m_byteenable_n,
    input  logic                m_waitrequest,
    input  logic [M_DATA_W-1:0] m_readdata,
    input  logic                m_readdatavalid
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(LOCK_LIMIT + 1);

    arb_state_t              state_q;
    logic [IDX_W-1:0]        owner_q;
    logic [IDX_W-1:0]        rr_ptr_q;
    logic [CNT_W-1:0]        lock_cnt_q;
    logic                    lock_valid_q;
    logic [M_ADDR_W-2:0]     word_addr_q;
    logic [S_DATA_W-1:0]     asm_q;
    logic [1:0]              beat_cnt_q;
    logic                    dropped_q;
    logic                    m_read_q;
    logic [M_ADDR_W-1:0]     m_address_q;
    logic [S_DATA_W-1:0]     rdata_q;
    logic [N_REQ-1:0]        rvalid_q;

    logic [N_REQ-1:0]        gnt;
    logic [IDX_W-1:0]        gnt_idx;
    logic                    gnt_valid;
    logic [31:0]             sel_addr;
    logic                    unused_addr_bits;
    logic [IDX_W-1:0]        next_ptr;
    logic                    capture;
    logic                    in_flight;

    rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_rr (
        .req_i        (rq_read),
        .ptr_i        (rr_ptr_q),
        .lock_owner_i (owner_q),
        .lock_valid_i (lock_valid_q),
        .grant_o      (gnt),
        .idx_o        (gnt_idx),
        .valid_o      (gnt_valid)
    );

    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) sel_addr = rq_address[i];
        end
    end

    // Byte offset and the top address bits have no place on the halfword bus.
    assign unused_addr_bits = ^{sel_addr[31:26], sel_addr[1:0]};

    assign next_ptr  = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign capture   = (state_q == ISSUE_HI || state_q == WAIT_DATA)
                       && m_readdatavalid && (beat_cnt_q != 2'd2);
    assign in_flight = (state_q == ISSUE_LO || state_q == ISSUE_HI || state_q == WAIT_DATA);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            lock_cnt_q   <= '0;
            lock_valid_q <= 1'b0;
            word_addr_q  <= '0;
            asm_q        <= '0;
            beat_cnt_q   <= '0;
            dropped_q    <= 1'b0;
            m_read_q     <= 1'b0;
            m_address_q  <= '0;
            rdata_q      <= '0;
            rvalid_q     <= '0;
        end else begin
            rvalid_q <= '0;
            if (capture) begin
                if (beat_cnt_q == 2'd0) asm_q[15:0]  <= m_readdata;
                else                    asm_q[31:16] <= m_readdata;
                beat_cnt_q <= beat_cnt_q + 2'd1;
            end
            if (in_flight && !rq_read[owner_q]) dropped_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    // Lock priority lasts one IDLE cycle; losing it restarts the run count.
                    lock_valid_q <= 1'b0;
                    if (lock_valid_q && !(gnt_valid && gnt_idx == owner_q)) lock_cnt_q <= '0;
                    if (gnt_valid) begin
                        owner_q     <= gnt_idx;
                        word_addr_q <= sel_addr[25:2];
                        m_address_q <= {sel_addr[25:2], 1'b0};
                        m_read_q    <= 1'b1;
                        beat_cnt_q  <= '0;
                        asm_q       <= '0;
                        dropped_q   <= 1'b0;
                        state_q     <= ISSUE_LO;
                    end
                end
                ISSUE_LO: begin
                    if (!m_waitrequest) begin
                        m_address_q <= {word_addr_q, 1'b1};
                        state_q     <= ISSUE_HI;
                    end
                end
                ISSUE_HI: begin
                    if (!m_waitrequest) begin
                        m_read_q <= 1'b0;
                        state_q  <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (beat_cnt_q == 2'd2) begin
                        rdata_q           <= asm_q;
                        rvalid_q[owner_q] <= ~dropped_q & rq_read[owner_q];
                        state_q           <= RESP;
                    end
                end
                RESP: begin
                    rr_ptr_q <= next_ptr;
                    if (rq_lock[owner_q] && lock_cnt_q < CNT_W'(LOCK_LIMIT)) begin
                        lock_cnt_q   <= lock_cnt_q + 1'b1;
                        lock_valid_q <= 1'b1;
                    end else begin
                        lock_cnt_q   <= '0;
                        lock_valid_q <= 1'b0;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_req
        assign rq_waitrequest[g] = rq_read[g] & ~(state_q == RESP && owner_q == IDX_W'(g));
        assign rq_readdata[g]    = rdata_q;
    end

    assign rq_readdatavalid = rvalid_q;
    assign m_address        = m_address_q;
    assign m_read           = m_read_q;
    assign m_byteenable_n   = 2'b00;

endmodule

// File: tb/tb_avalon_mm_read_arbiter.sv
// tb/tb_avalon_mm_read_arbiter.sv - directed self-checking bench for avalon_mm_read_arbiter
module tb_avalon_mm_read_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] rq_address [2];
    logic [1:0]  rq_read;
    logic [1:0]  rq_lock;
    logic [1:0]  rq_waitrequest;
    logic [31:0] rq_readdata [2];
    logic [1:0]  rq_readdatavalid;
    logic [24:0] m_address;
    logic        m_read;
    logic [1:0]  m_byteenable_n;
    logic        m_waitrequest   = 1'b0;
    logic [15:0] m_readdata      = 16'h0;
    logic        m_readdatavalid = 1'b0;

    always #5 clock = ~clock;

    avalon_mm_read_arbiter #(.N_REQ(2), .LOCK_LIMIT(8)) dut (
        .clock            (clock),
        .reset            (reset),
        .rq_address       (rq_address),
        .rq_read          (rq_read),
        .rq_lock          (rq_lock),
        .rq_waitrequest   (rq_waitrequest),
        .rq_readdata      (rq_readdata),
        .rq_readdatavalid (rq_readdatavalid),
        .m_address        (m_address),
        .m_read           (m_read),
        .m_byteenable_n   (m_byteenable_n),
        .m_waitrequest    (m_waitrequest),
        .m_readdata       (m_readdata),
        .m_readdatavalid  (m_readdatavalid)
    );

    int tick = 0;
    always @(posedge clock) tick <= tick + 1;

    function automatic logic [15:0] mem_beat(input logic [24:0] a);
        if (a == 25'h8) return 16'h1234;
        if (a == 25'h9) return 16'hABCD;
        return a[15:0] ^ 16'h5AC3;
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] byte_addr);
        return {mem_beat({byte_addr[25:2], 1'b1}), mem_beat({byte_addr[25:2], 1'b0})};
    endfunction

    // Memory model: beats accepted at a posedge return lat cycles later, in order.
    int          lat        = 1;
    logic [24:0] stall_addr = 25'h1FFFFFF;
    int          stall_n    = 0;
    int          stall_taken = 0;
    int          rsp_due [$];
    logic [15:0] rsp_data [$];
    logic [24:0] addr_log [$];

    always @(negedge clock) begin
        m_readdatavalid = 1'b0;
        if (rsp_due.size() > 0 && rsp_due[0] <= tick) begin
            m_readdatavalid = 1'b1;
            m_readdata      = rsp_data[0];
            rsp_data.delete(0);
            rsp_due.delete(0);
        end
        m_waitrequest = 1'b0;
        if (m_read) begin
            addr_log.push_back(m_address);
            if (m_address == stall_addr && stall_taken < stall_n) begin
                m_waitrequest = 1'b1;
                stall_taken++;
            end else begin
                rsp_data.push_back(mem_beat(m_address));
                rsp_due.push_back(tick + lat);
            end
        end else begin
            stall_taken = 0;
        end
    end

    int          checks   = 0;
    int          failures = 0;
    int          strobes  = 0;
    int          rem [2];
    int          c_idx [$];
    logic [31:0] c_data [$];
    logic        c_valid [$];
    int          c_tick [$];

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic obs();
        for (int i = 0; i < 2; i++) begin
            if (rq_readdatavalid[i]) strobes++;
            if (rq_read[i] && !rq_waitrequest[i]) begin
                c_idx.push_back(i);
                c_data.push_back(rq_readdata[i]);
                c_valid.push_back(rq_readdatavalid[i]);
                c_tick.push_back(tick);
                rem[i]--;
                if (rem[i] <= 0) rq_read[i] = 1'b0;
                else             rq_address[i] = rq_address[i] + 32'd4;
            end
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clock);
            obs();
        end
    endtask

    task automatic start(input int i, input logic [31:0] a, input int n, input logic lk);
        rq_address[i] = a;
        rem[i]        = n;
        rq_lock[i]    = lk;
        rq_read[i]    = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (rq_read != 2'b00 && n < budget) begin
            cycles(1);
            n++;
        end
        chk(tag, rq_read, 2'b00);
        cycles(2);
    endtask

    int bc, ba, t0, s0, lead;

    initial begin
        reset = 1'b1;
        rq_read = 2'b00;
        rq_lock = 2'b00;
        rq_address[0] = 32'h0;
        rq_address[1] = 32'h0;
        rem[0] = 0;
        rem[1] = 0;
        cycles(3);
        chk("rst_m_read", m_read, 1'b0);
        chk("rst_m_address", m_address, 25'h0);
        chk("rst_rdvalid", rq_readdatavalid, 2'b00);
        chk("rst_rdata0", rq_readdata[0], 32'h0);
        chk("rst_waitreq", rq_waitrequest, 2'b00);
        chk("byteenable_n", m_byteenable_n, 2'b00);
        reset = 1'b0;
        cycles(2);

        // Single read, zero wait states
        bc = c_idx.size(); ba = addr_log.size(); t0 = tick;
        start(0, 32'h0000_0010, 1, 1'b0);
        wait_done("t1_timeout", 30);
        chk("t1_count", c_idx.size() - bc, 1);
        chk("t1_owner", c_idx[bc], 0);
        chk("t1_data", c_data[bc], 32'hABCD1234);
        chk("t1_valid", c_valid[bc], 1'b1);
        chk("t1_latency", c_tick[bc] - t0, 5);
        chk("t1_addr_n", addr_log.size() - ba, 2);
        chk("t1_addr_lo", addr_log[ba], 25'h8);
        chk("t1_addr_hi", addr_log[ba + 1], 25'h9);

        // Simultaneous requests right after reset
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        cycles(1);
        bc = c_idx.size();
        start(0, 32'h0000_0100, 1, 1'b0);
        start(1, 32'h0000_0204, 1, 1'b0);
        wait_done("t2_timeout", 40);
        chk("t2_first", c_idx[bc], 0);
        chk("t2_second", c_idx[bc + 1], 1);
        chk("t2_data0", c_data[bc], exp_word(32'h100));
        chk("t2_data1", c_data[bc + 1], exp_word(32'h204));
        bc = c_idx.size();
        start(0, 32'h0000_0300, 1, 1'b0);
        start(1, 32'h0000_0404, 1, 1'b0);
        wait_done("t2b_timeout", 40);
        chk("t2_ptr_back_to_0", c_idx[bc], 0);

        // Lock: req1 keeps the bus for 1 + LOCK_LIMIT reads, then req0 gets in
        bc = c_idx.size();
        start(1, 32'h0000_1000, 10, 1'b1);
        cycles(2);
        start(0, 32'h0000_2000, 1, 1'b0);
        wait_done("t3_timeout", 300);
        rq_lock = 2'b00;
        lead = 0;
        for (int k = bc; k < c_idx.size() && c_idx[k] == 1; k++) lead++;
        chk("t3_count", c_idx.size() - bc, 11);
        chk("t3_locked_run", lead, 9);
        chk("t3_req0_next", c_idx[bc + 9], 0);
        chk("t3_req1_last", c_idx[bc + 10], 1);
        chk("t3_data_run_end", c_data[bc + 8], exp_word(32'h1020));
        chk("t3_data_req0", c_data[bc + 9], exp_word(32'h2000));

        // Low beat stalled three cycles
        stall_addr = 25'h20;
        stall_n = 3;
        bc = c_idx.size(); ba = addr_log.size(); t0 = tick;
        start(0, 32'h0000_0040, 1, 1'b0);
        wait_done("t4_timeout", 40);
        stall_n = 0;
        chk("t4_data", c_data[bc], 32'h5AE2_5AE3);
        chk("t4_latency", c_tick[bc] - t0, 8);
        chk("t4_addr_n", addr_log.size() - ba, 5);
        chk("t4_addr_held", {addr_log[ba], addr_log[ba + 1], addr_log[ba + 2], addr_log[ba + 3]},
            {25'h20, 25'h20, 25'h20, 25'h20});
        chk("t4_addr_hi", addr_log[ba + 4], 25'h21);

        // Reset during WAIT_DATA with slow memory; stale beats land in IDLE
        lat = 3;
        bc = c_idx.size(); s0 = strobes;
        start(0, 32'h0000_0080, 1, 1'b0);
        cycles(3);
        reset = 1'b1;
        rq_read[0] = 1'b0;
        rem[0] = 0;
        cycles(1);
        reset = 1'b0;
        cycles(6);
        lat = 1;
        chk("t5_no_strobe", strobes - s0, 0);
        chk("t5_no_completion", c_idx.size() - bc, 0);
        chk("t5_m_read_idle", m_read, 1'b0);
        bc = c_idx.size(); t0 = tick;
        start(0, 32'h0000_00C0, 1, 1'b0);
        wait_done("t5_timeout", 30);
        chk("t5_fresh_data", c_data[bc], exp_word(32'hC0));
        chk("t5_fresh_latency", c_tick[bc] - t0, 5);

        // Owner abandons its read once the low beat is issued
        bc = c_idx.size(); ba = addr_log.size(); s0 = strobes;
        start(0, 32'h0000_0020, 1, 1'b0);
        cycles(2);
        rq_read[0] = 1'b0;
        rem[0] = 0;
        cycles(8);
        chk("t6_no_strobe", strobes - s0, 0);
        chk("t6_addr_n", addr_log.size() - ba, 2);
        chk("t6_addr_lo", addr_log[ba], 25'h10);
        chk("t6_addr_hi", addr_log[ba + 1], 25'h11);
        chk("t6_m_read_idle", m_read, 1'b0);
        bc = c_idx.size(); t0 = tick;
        start(1, 32'h0000_0024, 1, 1'b0);
        wait_done("t6_timeout", 30);
        chk("t6_next_owner", c_idx[bc], 1);
        chk("t6_next_data", c_data[bc], exp_word(32'h24));
        chk("t6_next_latency", c_tick[bc] - t0, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
